// File: rtl/caesar_seq_ctrl_if.sv
// Load/readout signal bundle for caesar_seq_ctrl.
// Carries the decrypt request only when CAESAR_DECRYPT_EN is defined.
interface caesar_seq_ctrl_if;
  logic       go;
  logic [4:0] letter_in;
  logic [1:0] shift_in;
`ifdef CAESAR_DECRYPT_EN
  logic       decrypt;
`endif
  logic       out_ready;
  logic [4:0] cipher_out;
  logic       out_valid;
  logic [2:0] out_index;
  logic       busy;
  logic       err;

  modport master (
`ifdef CAESAR_DECRYPT_EN
    output decrypt,
`endif
    output go, letter_in, shift_in, out_ready,
    input  cipher_out, out_valid, out_index, busy, err
  );

  modport slave (
`ifdef CAESAR_DECRYPT_EN
    input  decrypt,
`endif
    input  go, letter_in, shift_in, out_ready,
    output cipher_out, out_valid, out_index, busy, err
  );
endinterface

// File: rtl/caesar_seq_ctrl.sv
// Caesar cipher sequencer: loads a message letter-by-letter, shifts it in place, reads it out.
// Optional decryption mode is enabled by defining CAESAR_DECRYPT_EN.
module caesar_seq_ctrl #(
  parameter int unsigned NUM_LETTERS = 6
) (
  input logic             clk,
  input logic             resetn,
  caesar_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StReadout} state_e;

  localparam logic [2:0] LastIdx = 3'(NUM_LETTERS - 1);

  state_e     state_q, state_d;
  logic [2:0] wr_ptr_q, wr_ptr_d;
  logic [2:0] rd_ptr_q, rd_ptr_d;
  logic [1:0] shift_q, shift_d;
  logic       err_q, err_d;
  logic       go_q;
`ifdef CAESAR_DECRYPT_EN
  logic       dec_q, dec_d;
`endif

  logic [4:0] mem_q [8];
  logic       mem_we;
  logic [2:0] mem_addr;
  logic [4:0] mem_wdata;

  logic       go_rise;
  logic       letter_ok;
  logic [5:0] sum;
  logic [4:0] shifted;

  assign go_rise   = bus.go & ~go_q;
  assign letter_ok = (bus.letter_in <= 5'd25);

  // 6-bit sum keeps the carry so 25+3 reduces to 2 instead of overflowing.
  always_comb begin
    sum = {1'b0, mem_q[rd_ptr_q]} + {4'd0, shift_q};
`ifdef CAESAR_DECRYPT_EN
    if (dec_q) sum = {1'b0, mem_q[rd_ptr_q]} + 6'd26 - {4'd0, shift_q};
`endif
    shifted = (sum >= 6'd26) ? 5'(sum - 6'd26) : sum[4:0];
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    shift_d   = shift_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_addr  = wr_ptr_q;
    mem_wdata = bus.letter_in;
`ifdef CAESAR_DECRYPT_EN
    dec_d     = dec_q;
`endif
    unique case (state_q)
      StIdle, StLoad: begin
        if (go_rise) begin
          if (state_q == StIdle) begin
            shift_d = bus.shift_in;
`ifdef CAESAR_DECRYPT_EN
            dec_d   = bus.decrypt;
`endif
            state_d = StLoad;
          end
          if (letter_ok) begin
            mem_we = 1'b1;
            if (wr_ptr_q == LastIdx) begin
              wr_ptr_d = 3'd0;
              state_d  = StShift;
            end else begin
              wr_ptr_d = wr_ptr_q + 3'd1;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StShift: begin
        mem_we    = 1'b1;
        mem_addr  = rd_ptr_q;
        mem_wdata = shifted;
        if (rd_ptr_q == LastIdx) begin
          rd_ptr_d = 3'd0;
          state_d  = StReadout;
        end else begin
          rd_ptr_d = rd_ptr_q + 3'd1;
        end
      end
      StReadout: begin
        if (bus.out_ready) begin
          if (rd_ptr_q == LastIdx) begin
            rd_ptr_d = 3'd0;
            state_d  = StIdle;
          end else begin
            rd_ptr_d = rd_ptr_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StIdle;
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      shift_q  <= 2'd0;
      err_q    <= 1'b0;
      go_q     <= 1'b0;
`ifdef CAESAR_DECRYPT_EN
      dec_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      shift_q  <= shift_d;
      err_q    <= err_d;
      go_q     <= bus.go;
`ifdef CAESAR_DECRYPT_EN
      dec_q    <= dec_d;
`endif
    end
  end

  // Message buffer needs no reset: every slot is written before it is read.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdata;
  end

  // Outputs are forced low combinationally while reset is held.
  assign bus.out_valid  = resetn && (state_q == StReadout);
  assign bus.cipher_out = bus.out_valid ? mem_q[rd_ptr_q] : 5'd0;
  assign bus.out_index  = bus.out_valid ? rd_ptr_q : 3'd0;
  assign bus.busy       = resetn && (state_q != StIdle);
  assign bus.err        = resetn && err_q;

endmodule

// File: tb/tb_caesar_seq_ctrl.sv
// Scoreboard bench for caesar_seq_ctrl: driver queues expected ciphertext, monitor checks readout.
module tb_caesar_seq_ctrl;
  localparam int N = 6;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  caesar_seq_ctrl_if bus();

  caesar_seq_ctrl #(.NUM_LETTERS(N)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_c[$];
  int exp_i[$];
  int msg[$];
  bit err_exp = 1'b0;
  int rdy_mode = 0;
  int stall_cnt = 0;
  int stall_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain modular arithmetic on letter indices.
  function automatic int model(input int l, input int sh, input bit dec);
    return dec ? (l + 26 - sh) % 26 : (l + sh) % 26;
  endfunction

  // Ready driver
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: bus.out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (bus.out_valid && bus.out_index == 3'd3 && stall_cnt < 5) begin
            bus.out_ready = 1'b0;
            stall_cnt++;
          end else begin
            bus.out_ready = 1'b1;
          end
        end
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Monitor
  initial begin
    bit prev_hold = 1'b0;
    int prev_c = 0;
    int prev_i = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("hold_valid", int'(bus.out_valid), 1);
          check("hold_cipher", int'(bus.cipher_out), prev_c);
          check("hold_index", int'(bus.out_index), prev_i);
        end
        if (bus.out_valid) begin
          if (exp_c.size() == 0) begin
            check("unexpected_valid", int'(bus.out_valid), 0);
          end else begin
            check("cipher_out", int'(bus.cipher_out), exp_c[0]);
            check("out_index", int'(bus.out_index), exp_i[0]);
            if (!bus.out_ready && bus.out_index == 3'd3) stall_seen++;
            if (bus.out_ready) begin
              void'(exp_c.pop_front());
              void'(exp_i.pop_front());
            end
          end
        end
        prev_hold = bus.out_valid && !bus.out_ready;
        prev_c = int'(bus.cipher_out);
        prev_i = int'(bus.out_index);
      end
    end
  end

  // Sends msg[]; hold_idx letter keeps go high 10 cycles; abort resets in the 3rd SHIFT cycle.
  task automatic send_msg(input int sh, input bit dec, input int hold_idx, input bit abort);
    int legal = 0;
    int lat;
    for (int i = 0; i < msg.size(); i++) begin
      bus.letter_in = 5'(msg[i]);
      bus.shift_in = 2'(sh);
`ifdef CAESAR_DECRYPT_EN
      bus.decrypt = dec;
`endif
      bus.go = 1'b1;
      if (msg[i] <= 25) begin
        exp_c.push_back(model(msg[i], sh, dec));
        exp_i.push_back(legal);
        legal++;
      end else begin
        err_exp = 1'b1;
      end
      if (legal == N && msg[i] <= 25) begin
        if (abort) begin
          tick();
          bus.go = 1'b0;
          tick();
          tick();
          check("abort_busy_before", int'(bus.busy), 1);
          check("abort_err_before", int'(bus.err), int'(err_exp));
          resetn = 1'b0;
          exp_c.delete();
          exp_i.delete();
          tick();
          check("abort_busy", int'(bus.busy), 0);
          check("abort_valid", int'(bus.out_valid), 0);
          check("abort_err", int'(bus.err), 0);
          check("abort_cipher", int'(bus.cipher_out), 0);
          check("abort_index", int'(bus.out_index), 0);
          err_exp = 1'b0;
          resetn = 1'b1;
          tick();
        end else begin
          lat = 0;
          while (!bus.out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            #1;
            bus.go = 1'b0;
          end
          check("latency", lat, N + 1);
        end
        return;
      end
      tick();
      if (i == hold_idx) begin
        repeat (9) begin
          bus.letter_in = 5'($urandom_range(0, 25));
          tick();
        end
      end
      bus.go = 1'b0;
      if (msg[i] > 25) check("err_set", int'(bus.err), 1);
      tick();
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_c.size() != 0 || bus.busy) && n < 500) begin
      tick();
      n++;
    end
    check({name, "_drained"}, exp_c.size(), 0);
    tick();
    check({name, "_busy_idle"}, int'(bus.busy), 0);
    check({name, "_valid_idle"}, int'(bus.out_valid), 0);
    check({name, "_err"}, int'(bus.err), int'(err_exp));
  endtask

  initial begin
    bus.go = 1'b0;
    bus.letter_in = 5'd0;
    bus.shift_in = 2'd0;
`ifdef CAESAR_DECRYPT_EN
    bus.decrypt = 1'b0;
`endif
    repeat (3) tick();
    check("rst_busy", int'(bus.busy), 0);
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_cipher", int'(bus.cipher_out), 0);
    check("rst_index", int'(bus.out_index), 0);
    resetn = 1'b1;
    tick();

    // Basic message, wrap of 25+2
    msg = '{7, 4, 11, 11, 14, 25};
    send_msg(2, 1'b0, -1, 1'b0);
    drain("basic");

    // go held high for 10 cycles on slot 2
    msg = '{2, 8, 19, 0, 22, 13};
    send_msg(1, 1'b0, 2, 1'b0);
    drain("held_go");

    // Illegal letter: err sticks and next letter fills same slot
    msg = '{5, 30, 9, 3, 21, 25, 0};
    send_msg(3, 1'b0, -1, 1'b0);
    drain("illegal");

    // Stall five cycles at index 3
    rdy_mode = 2;
    stall_cnt = 0;
    stall_seen = 0;
    msg = '{7, 4, 11, 11, 14, 25};
    send_msg(2, 1'b0, -1, 1'b0);
    drain("stall");
    check("stall_cycles", stall_seen, 5);
    rdy_mode = 0;

    // Reset in the 3rd SHIFT cycle (err set beforehand)
    msg = '{1, 27, 2, 3, 4, 5, 6};
    send_msg(0, 1'b0, -1, 1'b1);
    msg = '{0, 1, 2, 3, 24, 25};
    send_msg(3, 1'b0, -1, 1'b0);
    drain("after_abort");

`ifdef CAESAR_DECRYPT_EN
    msg = '{1, 0, 25, 2, 3, 13};
    send_msg(3, 1'b1, -1, 1'b0);
    drain("decrypt");
`endif

    // Randomized messages with random backpressure
    rdy_mode = 1;
    for (int m = 0; m < 20; m++) begin
      int legal = 0;
      bit dec = 1'b0;
`ifdef CAESAR_DECRYPT_EN
      dec = 1'($urandom_range(0, 1));
`endif
      msg.delete();
      while (legal < N) begin
        if ($urandom_range(0, 9) == 0) begin
          msg.push_back(26 + $urandom_range(0, 5));
        end else begin
          msg.push_back($urandom_range(0, 25));
          legal++;
        end
      end
      send_msg($urandom_range(0, 3), dec, -1, 1'b0);
      drain("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0t expected=finish", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/caesar_seq_ctrl.md
CAESAR_SEQ_CTRL -- requirements
Module: caesar_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_LETTERS, default 6, giving the number of letters per message (legal range 1..8).
REQ-002 The block SHALL have port clk, input, 1, the system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1, the reset: synchronous, active-low.
REQ-004 The block SHALL have port go, input, 1, the load request, a level from a debounced key; a letter is captured on its 0->1 transition.
REQ-005 The block SHALL have port letter_in, input, 5, the plaintext letter index (A=0 .. Z=25).
REQ-006 The block SHALL have port shift_in, input, 2, the shift amount (0..3).
REQ-007 The block SHALL have port out_ready, input, 1, the consumer-ready signal for readout.
REQ-008 The block SHALL have port cipher_out, output, 5, the ciphertext letter index.
REQ-009 The block SHALL have port out_valid, output, 1, asserted when cipher_out holds valid data.
REQ-010 The block SHALL have port out_index, output, 3, the position of cipher_out within the message.
REQ-011 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 The block SHALL have port err, output, 1, a sticky flag for an illegal letter.

Function
REQ-013 The block SHALL implement states IDLE, LOAD, SHIFT and READOUT.
REQ-014 IDLE SHALL go to LOAD on the first go rising edge; that edge captures letter 0 and latches shift_in for the whole message.
REQ-015 In LOAD, each later go rising edge SHALL capture letter_in into buffer slot wr_ptr and increment wr_ptr.
REQ-016 A go level held high SHALL capture exactly one letter.
REQ-017 Capturing slot NUM_LETTERS-1 SHALL move the block to SHIFT on the next cycle.
REQ-018 A letter_in value above 25 SHALL set err, SHALL NOT be stored and SHALL NOT advance wr_ptr.
REQ-019 err SHALL clear only on reset.
REQ-020 SHIFT SHALL process one slot per cycle in index order: slot = (slot + shift) mod 26, computed with 6-bit intermediate width so that 25+3 wraps to 2.
REQ-021 SHIFT SHALL last exactly NUM_LETTERS cycles and then enter READOUT.
REQ-022 In READOUT, cipher_out and out_index SHALL present slot rd_ptr with out_valid=1.
REQ-023 rd_ptr SHALL advance only in a cycle where out_valid and out_ready are both 1.
REQ-024 cipher_out and out_index SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 The handshake on the last slot SHALL return the block to IDLE with out_valid deasserted the following cycle.
REQ-026 go edges during SHIFT or READOUT SHALL be ignored.
REQ-027 out_valid SHALL be 0 in IDLE, LOAD and SHIFT.
REQ-028 Latency SHALL be NUM_LETTERS+1 cycles from the final capture to the first out_valid.

Reset
REQ-029 When resetn=0 at a clock edge, state SHALL become IDLE in any state, including mid-LOAD, mid-SHIFT and mid-READOUT.
REQ-030 Reset SHALL clear wr_ptr, rd_ptr, the latched shift, err and the go edge-detect register.
REQ-031 During reset, outputs SHALL be cipher_out=0, out_valid=0, out_index=0, busy=0 and err=0.
REQ-032 Buffer contents SHALL NOT need to be cleared by reset.

Configuration
REQ-033 With macro CAESAR_DECRYPT_EN defined, the block SHALL have an extra input decrypt, 1 bit, latched with the first letter.
REQ-034 With CAESAR_DECRYPT_EN defined and decrypt=1, SHIFT SHALL compute (slot + 26 - shift) mod 26.
REQ-035 Without CAESAR_DECRYPT_EN, the decrypt port SHALL be absent and the block SHALL only encrypt.

Verification
REQ-036 The bench SHALL cover: letters 7,4,11,11,14,25 with shift 2 and out_ready=1 -> outputs 9,6,13,13,16,1 at out_index 0..5, then IDLE.
REQ-037 The bench SHALL cover: go held high for 10 cycles during LOAD -> exactly one letter captured and wr_ptr +1.
REQ-038 The bench SHALL cover: letter_in=30 captured in LOAD -> err=1 and wr_ptr unchanged; the next valid letter fills the same slot.
REQ-039 The bench SHALL cover: out_ready low for 5 cycles at out_index 3 -> cipher_out and out_index held, out_valid stays 1.
REQ-040 The bench SHALL cover: resetn=0 in the 3rd SHIFT cycle -> next cycle busy=0, out_valid=0, err=0 and state IDLE.
REQ-041 The bench SHALL cover, with CAESAR_DECRYPT_EN defined: decrypt=1, shift 3, letter 1 -> cipher_out=24.
